exe_alu_val2: RTL and testbench

- Execute-stage datapath core of the ARM pipeline.
- Val2 generator: forms the second ALU operand from the forwarded Rm value, a rotated 8-bit immediate, or a 12-bit memory offset.
- ALU: applies the EXE command to Val1/Val2 and produces the result plus NZCV flags.
- Result and flags are registered once before leaving the block; the surrounding stage handles muxing, forwarding and branch-address adders.

---
 rtl/exe_alu_val2.sv | 122 ++++++++++++
 tb/tb_exe_alu_val2.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/exe_alu_val2.sv
// Execute-stage operand-2 generator and ALU for the ARM pipeline.
// Result and NZCV flags are registered once; val2 leaves combinationally.
module exe_alu_val2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] val1,
    input  logic [WIDTH-1:0] val_rm,
    input  logic             imm,
    input  logic             mem_en,
    input  logic [11:0]      shift_operand,
    input  logic [3:0]       exe_cmd,
    input  logic             carry_in,
    output logic [WIDTH-1:0] val2,
    output logic [WIDTH-1:0] alu_result,
    output logic [3:0]       status
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    logic [4:0]         imm_rot;
    logic [4:0]         sh_amt;
    logic [1:0]         sh_type;
    logic [2*WIDTH-1:0] imm_dbl;
    logic [2*WIDTH-1:0] rm_dbl;
    logic [WIDTH-1:0]   reg_val;
    logic               unused_sh4;

    assign unused_sh4 = shift_operand[4];
    assign imm_rot    = {shift_operand[11:8], 1'b0};
    assign sh_amt     = shift_operand[11:7];
    assign sh_type    = shift_operand[6:5];

    // Rotates are done on a doubled word so amount 0 needs no special case.
    always_comb begin
        imm_dbl = {2{24'b0, shift_operand[7:0]}} >> imm_rot;
        rm_dbl  = {val_rm, val_rm} >> sh_amt;
        reg_val = val_rm;
        unique case (sh_type)
            2'b00:   reg_val = val_rm << sh_amt;
            2'b01:   reg_val = val_rm >> sh_amt;
            2'b10:   reg_val = $signed(val_rm) >>> sh_amt;
            default: reg_val = rm_dbl[WIDTH-1:0];
        endcase
    end

    always_comb begin
        if (mem_en)
            val2 = {20'b0, shift_operand};
        else if (imm)
            val2 = imm_dbl[WIDTH-1:0];
        else
            val2 = reg_val;
    end

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_sum;
    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       flags_d;
    logic [3:0]       flags_q;
    logic             c_d;
    logic             v_d;
    logic             add_cin;
    logic             sub_cin;

    assign add_cin = (exe_cmd == CMD_ADC) ? carry_in : 1'b0;
    assign sub_cin = (exe_cmd == CMD_SBC) ? carry_in : 1'b1;
    assign add_sum = {1'b0, val1} + {1'b0, val2} + {{WIDTH{1'b0}}, add_cin};
    // Subtract as A + ~B + cin; the carry out is the ARM not-borrow.
    assign sub_sum = {1'b0, val1} + {1'b0, ~val2} + {{WIDTH{1'b0}}, sub_cin};

    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        unique case (exe_cmd)
            CMD_MOV: res_d = val2;
            CMD_MVN: res_d = ~val2;
            CMD_ADD, CMD_ADC: begin
                res_d = add_sum[WIDTH-1:0];
                c_d   = add_sum[WIDTH];
                v_d   = (val1[WIDTH-1] == val2[WIDTH-1]) &&
                        (add_sum[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_SUB, CMD_SBC: begin
                res_d = sub_sum[WIDTH-1:0];
                c_d   = sub_sum[WIDTH];
                v_d   = (val1[WIDTH-1] != val2[WIDTH-1]) &&
                        (sub_sum[WIDTH-1] != val1[WIDTH-1]);
            end
            CMD_AND: res_d = val1 & val2;
            CMD_ORR: res_d = val1 | val2;
            CMD_EOR: res_d = val1 ^ val2;
            default: res_d = '0;
        endcase
        flags_d = {res_d[WIDTH-1], (res_d == '0), c_d, v_d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_q   <= '0;
            flags_q <= 4'b0000;
        end else begin
            res_q   <= res_d;
            flags_q <= flags_d;
        end
    end

    assign alu_result = res_q;
    assign status     = flags_q;

endmodule

// File: tb/tb_exe_alu_val2.sv
// Directed vector bench for exe_alu_val2: val2 forms, ALU ops, flags, reset.
module tb_exe_alu_val2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] val1;
    logic [31:0] val_rm;
    logic        imm;
    logic        mem_en;
    logic [11:0] shift_operand;
    logic [3:0]  exe_cmd;
    logic        carry_in;
    logic [31:0] val2;
    logic [31:0] alu_result;
    logic [3:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    exe_alu_val2 dut (
        .clk           (clk),
        .rst           (rst),
        .val1          (val1),
        .val_rm        (val_rm),
        .imm           (imm),
        .mem_en        (mem_en),
        .shift_operand (shift_operand),
        .exe_cmd       (exe_cmd),
        .carry_in      (carry_in),
        .val2          (val2),
        .alu_result    (alu_result),
        .status        (status)
    );

    typedef struct {
        string       name;
        logic        imm;
        logic        mem_en;
        logic [11:0] so;
        logic [31:0] val1;
        logic [31:0] val_rm;
        logic [3:0]  cmd;
        logic        cin;
        logic [31:0] exp_val2;
        logic [31:0] exp_res;
        logic [3:0]  exp_st;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(string n, logic i, logic m, logic [11:0] so,
                                logic [31:0] a, logic [31:0] rm,
                                logic [3:0] c, logic ci, logic [31:0] v2,
                                logic [31:0] r, logic [3:0] st);
        vec_t v;
        v.name = n; v.imm = i; v.mem_en = m; v.so = so;
        v.val1 = a; v.val_rm = rm; v.cmd = c; v.cin = ci;
        v.exp_val2 = v2; v.exp_res = r; v.exp_st = st;
        return v;
    endfunction

    task automatic drive(input logic i, input logic m, input logic [11:0] so,
                         input logic [31:0] a, input logic [31:0] rm,
                         input logic [3:0] c, input logic ci);
        imm = i; mem_en = m; shift_operand = so;
        val1 = a; val_rm = rm; exe_cmd = c; carry_in = ci;
    endtask

    initial begin
        vecs[0]  = mk("imm_rot_mov", 1, 0, 12'h2FF, 0, 0, 4'h1, 0,
                      32'hF000000F, 32'hF000000F, 4'b1000);
        vecs[1]  = mk("lsl1", 0, 0, 12'h080, 0, 32'h80000001, 4'h1, 0,
                      32'h00000002, 32'h00000002, 4'b0000);
        vecs[2]  = mk("lsr1", 0, 0, 12'h0A0, 0, 32'h80000001, 4'h1, 0,
                      32'h40000000, 32'h40000000, 4'b0000);
        vecs[3]  = mk("asr1", 0, 0, 12'h0C0, 0, 32'h80000001, 4'h1, 0,
                      32'hC0000000, 32'hC0000000, 4'b1000);
        vecs[4]  = mk("ror1", 0, 0, 12'h0E0, 0, 32'h80000001, 4'h1, 0,
                      32'hC0000000, 32'hC0000000, 4'b1000);
        vecs[5]  = mk("amt0", 0, 0, 12'h040, 0, 32'h80000001, 4'h1, 0,
                      32'h80000001, 32'h80000001, 4'b1000);
        vecs[6]  = mk("lsl31", 0, 0, 12'hF80, 0, 32'h00000003, 4'h1, 0,
                      32'h80000000, 32'h80000000, 4'b1000);
        vecs[7]  = mk("asr31", 0, 0, 12'hFC0, 0, 32'h80000000, 4'h1, 0,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1000);
        vecs[8]  = mk("ror8_ign4", 0, 0, 12'h470, 0, 32'h12345678, 4'h1, 0,
                      32'h78123456, 32'h78123456, 4'b0000);
        vecs[9]  = mk("mem_prio", 1, 1, 12'hFFF, 32'h1000, 0, 4'h2, 0,
                      32'h00000FFF, 32'h00001FFF, 4'b0000);
        vecs[10] = mk("add_ovf", 1, 0, 12'h001, 32'h7FFFFFFF, 0, 4'h2, 0,
                      32'h1, 32'h80000000, 4'b1001);
        vecs[11] = mk("add_carry", 1, 0, 12'h001, 32'hFFFFFFFF, 0, 4'h2, 0,
                      32'h1, 32'h00000000, 4'b0110);
        vecs[12] = mk("adc", 1, 0, 12'h001, 32'h1, 0, 4'h3, 1,
                      32'h1, 32'h00000003, 4'b0000);
        vecs[13] = mk("sub_eq", 1, 0, 12'h005, 32'h5, 0, 4'h4, 0,
                      32'h5, 32'h00000000, 4'b0110);
        vecs[14] = mk("sub_neg", 1, 0, 12'h005, 32'h3, 0, 4'h4, 1,
                      32'h5, 32'hFFFFFFFE, 4'b1000);
        vecs[15] = mk("sbc", 1, 0, 12'h002, 32'h5, 0, 4'h5, 0,
                      32'h2, 32'h00000002, 4'b0010);
        vecs[16] = mk("sub_ovf", 1, 0, 12'h001, 32'h80000000, 0, 4'h4, 0,
                      32'h1, 32'h7FFFFFFF, 4'b0011);
        vecs[17] = mk("and", 1, 0, 12'hCFF, 32'hF0F0, 0, 4'h6, 1,
                      32'hFF00, 32'h0000F000, 4'b0000);
        vecs[18] = mk("orr", 1, 0, 12'hCFF, 32'hF0F0, 0, 4'h7, 1,
                      32'hFF00, 32'h0000FFF0, 4'b0000);
        vecs[19] = mk("eor", 1, 0, 12'hCFF, 32'hF0F0, 0, 4'h8, 1,
                      32'hFF00, 32'h00000FF0, 4'b0000);
        vecs[20] = mk("mvn0", 1, 0, 12'h000, 0, 0, 4'h9, 0,
                      32'h0, 32'hFFFFFFFF, 4'b1000);
        vecs[21] = mk("undef", 1, 0, 12'h000, 32'hFFFF, 0, 4'hF, 1,
                      32'h0, 32'h00000000, 4'b0100);

        // Reset holds outputs at zero with no clock edge needed.
        rst = 1'b0;
        drive(1, 0, 12'h005, 32'h5, 0, 4'h2, 0);
        #3;
        chk("rst_res", alu_result, 32'h0);
        chk("rst_st", {28'b0, status}, 32'h0);
        chk("rst_val2", val2, 32'h5);
        @(negedge clk);
        @(negedge clk);
        chk("rst_hold_res", alu_result, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_first_res", alu_result, 32'hA);
        chk("rst_first_st", {28'b0, status}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].imm, vecs[i].mem_en, vecs[i].so, vecs[i].val1,
                  vecs[i].val_rm, vecs[i].cmd, vecs[i].cin);
            #1;
            chk({vecs[i].name, "_val2"}, val2, vecs[i].exp_val2);
            @(posedge clk);
            #1;
            chk({vecs[i].name, "_res"}, alu_result, vecs[i].exp_res);
            chk({vecs[i].name, "_st"}, {28'b0, status},
                {28'b0, vecs[i].exp_st});
        end

        // Mid-stream async reset discards the captured result at once.
        @(negedge clk);
        drive(1, 0, 12'h001, 32'h7FFFFFFF, 0, 4'h2, 0);
        @(posedge clk);
        #1;
        chk("mid_pre_res", alu_result, 32'h80000000);
        #1;
        rst = 1'b0;
        #1;
        chk("mid_rst_res", alu_result, 32'h0);
        chk("mid_rst_st", {28'b0, status}, 32'h0);
        @(posedge clk);
        #1;
        chk("mid_rst_hold", alu_result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 12'h003, 32'h4, 0, 4'h4, 0);
        @(posedge clk);
        #1;
        chk("mid_rel_res", alu_result, 32'h1);
        chk("mid_rel_st", {28'b0, status}, 32'h2);

        // Back-to-back commands: each edge captures only the current inputs.
        @(negedge clk);
        drive(1, 0, 12'h0FF, 32'h1, 0, 4'h2, 0);
        @(posedge clk);
        #1;
        chk("b2b_a", alu_result, 32'h100);
        @(negedge clk);
        drive(1, 0, 12'h0FF, 32'h1, 0, 4'h4, 0);
        @(posedge clk);
        #1;
        chk("b2b_b", alu_result, 32'hFFFFFF02);
        chk("b2b_b_st", {28'b0, status}, 32'h8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
